// File: rtl/tmds_pkg.sv
// Shared definitions for the pipelined TMDS encoder: lane modes, fixed
// guard-band / reset symbols and the control / TERC4 symbol lookups.
package tmds_pkg;

  typedef enum logic [2:0] {
    CONTROL      = 3'd0,
    VIDEO        = 3'd1,
    VIDEO_GUARD  = 3'd2,
    ISLAND       = 3'd3,
    ISLAND_GUARD = 3'd4,
    RAW          = 3'd5
  } mode_t;

  localparam logic [9:0] VGB_A        = 10'b1011001100;
  localparam logic [9:0] VGB_B        = 10'b0100110011;
  localparam logic [9:0] RESET_SYMBOL = 10'b1101010100;

  // Control period symbols, indexed by {C1, C0}.
  function automatic logic [9:0] control_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  // TERC4 code table for data-island payload nibbles.
  function automatic logic [9:0] terc4_symbol(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Number of ones in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder_pipe_lane.sv
// One TMDS lane: stage 1 registers the inputs and the transition-minimised
// q_m word, stage 2 applies the DC-balance decision and owns the running
// disparity accumulator. Optional raw pass-through under TMDS_RAW_MODE_EN.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int CN        = 0,
  parameter int ACC_WIDTH = 5
) (
  input  logic                        clk_pixel,
  input  logic                        reset,
  input  logic [2:0]                  mode,
  input  logic [7:0]                  video_data,
  input  logic [3:0]                  data_island_data,
  input  logic [1:0]                  control_data,
  input  logic [9:0]                  raw_data,
  output logic [9:0]                  tmds,
  output logic signed [ACC_WIDTH-1:0] disparity
);

  // Stage 1 state
  mode_t      mode_d, mode_q;
  logic [1:0] ctrl_d, ctrl_q;
  logic [3:0] terc4_d, terc4_q;
  logic [8:0] qm_d, qm_q;
  logic [3:0] n1_d, n1_q;
  logic [3:0] n1_video;
  logic       use_xnor;

`ifdef TMDS_RAW_MODE_EN
  logic [9:0] raw_d, raw_q;
  assign raw_d = raw_data;
`else
  // Raw symbols are not part of this build; the port is left dangling.
  logic unused_raw;
  assign unused_raw = ^raw_data;
`endif

  // Stage 1: choose XOR/XNOR chain and build q_m plus its ones count
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
    qm_d     = '0;
    n1_video = popcount8(video_data);
    use_xnor = (n1_video > 4'd4) || ((n1_video == 4'd4) && !video_data[0]);
    qm_d[0]  = video_data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ video_data[i]) : (qm_d[i-1] ^ video_data[i]);
    qm_d[8]  = ~use_xnor;
    n1_d     = popcount8(qm_d[7:0]);
    mode_d   = mode_t'(mode);
    ctrl_d   = control_data;
    terc4_d  = data_island_data;
  end

  // Stage 1 registers, cleared asynchronously
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      mode_q  <= CONTROL;
      ctrl_q  <= '0;
      terc4_q <= '0;
      qm_q    <= '0;
      n1_q    <= '0;
`ifdef TMDS_RAW_MODE_EN
      raw_q   <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      ctrl_q  <= ctrl_d;
      terc4_q <= terc4_d;
      qm_q    <= qm_d;
      n1_q    <= n1_d;
`ifdef TMDS_RAW_MODE_EN
      raw_q   <= raw_d;
`endif
    end
  end

  // Stage 2 state
  logic [9:0]                  tmds_d, tmds_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] n1_minus_n0, n0_minus_n1, two_qm8, two_not_qm8;
  logic                        acc_pos, acc_neg, qm8;

  // Stage 2: symbol selection and running-disparity update
  always_comb begin
    qm8         = qm_q[8];
    // N0 = 8 - N1, so N1 - N0 = 2*N1 - 8 (wraps modulo 2^ACC_WIDTH)
    n1_minus_n0 = ACC_WIDTH'({n1_q, 1'b0}) - ACC_WIDTH'(8);
    n0_minus_n1 = -n1_minus_n0;
    two_qm8     = ACC_WIDTH'({qm8, 1'b0});
    two_not_qm8 = ACC_WIDTH'({~qm8, 1'b0});
    acc_neg     = acc_q[ACC_WIDTH-1];
    acc_pos     = !acc_neg && (acc_q != '0);
    // Invalid modes hold the symbol; every non-video mode clears the accumulator
    tmds_d      = tmds_q;
    acc_d       = '0;
    case (mode_q)
      VIDEO: begin
        if ((acc_q == '0) || (n1_q == 4'd4)) begin
          tmds_d = {~qm8, qm8, qm8 ? qm_q[7:0] : ~qm_q[7:0]};
          acc_d  = acc_q + (qm8 ? n1_minus_n0 : n0_minus_n1);
        end else if ((acc_pos && (n1_q > 4'd4)) || (acc_neg && (n1_q < 4'd4))) begin
          tmds_d = {1'b1, qm8, ~qm_q[7:0]};
          acc_d  = acc_q + n0_minus_n1 + two_qm8;
        end else begin
          tmds_d = {1'b0, qm8, qm_q[7:0]};
          acc_d  = acc_q + n1_minus_n0 - two_not_qm8;
        end
      end
      CONTROL:      tmds_d = control_symbol(ctrl_q);
      VIDEO_GUARD:  tmds_d = (CN == 1) ? VGB_B : VGB_A;
      ISLAND:       tmds_d = terc4_symbol(terc4_q);
      ISLAND_GUARD: tmds_d = (CN == 0) ? terc4_symbol({2'b11, ctrl_q}) : VGB_B;
`ifdef TMDS_RAW_MODE_EN
      RAW:          tmds_d = raw_q;
`endif
      default: ;
    endcase
  end

  // Stage 2 registers; reset drives the control-00 symbol onto the link
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      tmds_q <= RESET_SYMBOL;
      acc_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      acc_q  <= acc_d;
    end
  end

  assign tmds      = tmds_q;
  assign disparity = acc_q;

endmodule

// File: rtl/tmds_encoder_pipe.sv
// Multi-lane two-stage TMDS encoder with one shared mode. Fixed latency of
// two clk_pixel cycles in every mode. Define TMDS_RAW_MODE_EN to enable
// mode 5 (raw 10-bit symbol pass-through); otherwise mode 5 holds.
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int ACC_WIDTH    = 5
) (
  input  logic                              clk_pixel,
  input  logic                              reset,
  input  logic [2:0]                        mode,
  input  logic [8*NUM_CHANNELS-1:0]         video_data,
  input  logic [4*NUM_CHANNELS-1:0]         data_island_data,
  input  logic [2*NUM_CHANNELS-1:0]         control_data,
  input  logic [10*NUM_CHANNELS-1:0]        raw_data,
  output logic [10*NUM_CHANNELS-1:0]        tmds,
  output logic [ACC_WIDTH*NUM_CHANNELS-1:0] disparity
);

  // One lane per channel; guard-band channel number repeats every three lanes
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    tmds_lane #(
      .CN        (i % 3),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk_pixel        (clk_pixel),
      .reset            (reset),
      .mode             (mode),
      .video_data       (video_data[8*i +: 8]),
      .data_island_data (data_island_data[4*i +: 4]),
      .control_data     (control_data[2*i +: 2]),
      .raw_data         (raw_data[10*i +: 10]),
      .tmds             (tmds[10*i +: 10]),
      .disparity        (disparity[ACC_WIDTH*i +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Directed bench for tmds_encoder_pipe with four lanes (CN = 0,1,2,0).
module tb_tmds_encoder_pipe;

  localparam int NCH = 4;
  localparam int AW  = 5;

  logic                  clk_pixel = 1'b0;
  logic                  reset;
  logic [2:0]            mode;
  logic [8*NCH-1:0]      video_data;
  logic [4*NCH-1:0]      data_island_data;
  logic [2*NCH-1:0]      control_data;
  logic [10*NCH-1:0]     raw_data;
  logic [10*NCH-1:0]     tmds;
  logic [AW*NCH-1:0]     disparity;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

`ifdef TMDS_RAW_MODE_EN
  localparam logic [9:0] RAW_EXP = 10'b1010101010;
`else
  localparam logic [9:0] RAW_EXP = 10'b1111111111;
`endif

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder_pipe #(.NUM_CHANNELS(NCH), .ACC_WIDTH(AW)) dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .mode             (mode),
    .video_data       (video_data),
    .data_island_data (data_island_data),
    .control_data     (control_data),
    .raw_data         (raw_data),
    .tmds             (tmds),
    .disparity        (disparity)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] sym(input int lane);
    return tmds[lane*10 +: 10];
  endfunction

  function automatic int disp(input int lane);
    logic signed [AW-1:0] d;
    d = disparity[lane*AW +: AW];
    return int'(d);
  endfunction

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mode             = 3'($urandom_range(0, 7));
      video_data       = 32'($urandom);
      data_island_data = 16'($urandom);
      control_data     = 8'($urandom);
      raw_data         = 40'({$urandom, $urandom});
      tick();
    end
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("reset_sym_l%0d", i), 32'(sym(i)), 32'(10'b1101010100));
      check($sformatf("reset_disp_l%0d", i), disp(i), 0);
    end
    mode = 3'd0; video_data = '0; data_island_data = '0; control_data = '0; raw_data = '0;
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NCH; i++)
      check($sformatf("post_reset_l%0d", i), 32'(sym(i)), 32'(10'b1101010100));

    // ---------------- video DC balance and mode switch ----------------
    mode = 3'd1;
    video_data = {8'h10, 8'h55, 8'hFF, 8'h00};
    tick();                                   // V1 captured
    tick();                                   // V1 out
    check("v1_sym_l0", 32'(sym(0)), 32'(10'b0100000000));
    check("v1_disp_l0", disp(0), -8);
    check("v1_sym_l1", 32'(sym(1)), 32'(10'b1000000000));
    check("v1_disp_l1", disp(1), -8);
    check("v1_sym_l2", 32'(sym(2)), 32'(10'b0100110011));
    check("v1_disp_l2", disp(2), 0);
    check("v1_sym_l3", 32'(sym(3)), 32'(10'b0111110000));
    tick();                                   // V2 out, V3 captured
    check("v2_sym_l0", 32'(sym(0)), 32'(10'b1111111111));
    check("v2_disp_l0", disp(0), 2);
    check("v2_sym_l1", 32'(sym(1)), 32'(10'b0011111111));
    check("v2_disp_l1", disp(1), -2);
    mode = 3'd0; control_data = 8'h55;
    tick();                                   // V3 out, control captured
    check("v3_sym_l0", 32'(sym(0)), 32'(10'b0100000000));
    check("v3_disp_l0", disp(0), -6);
    check("v3_sym_l1", 32'(sym(1)), 32'(10'b0011111111));
    check("v3_disp_l1", disp(1), 4);
    mode = 3'd1;
    tick();                                   // control out
    check("ctl_sym_l0", 32'(sym(0)), 32'(10'b0010101011));
    check("ctl_sym_l3", 32'(sym(3)), 32'(10'b0010101011));
    check("ctl_disp_l0", disp(0), 0);
    check("ctl_disp_l1", disp(1), 0);
    tick();                                   // video again from acc = 0
    check("rev_sym_l0", 32'(sym(0)), 32'(10'b0100000000));
    check("rev_disp_l0", disp(0), -8);
    check("rev_sym_l1", 32'(sym(1)), 32'(10'b1000000000));

    // ---------------- asynchronous reset mid-video ----------------
    #2;
    reset = 1'b1;
    #1;
    check("async_sym_l0", 32'(sym(0)), 32'(10'b1101010100));
    check("async_disp_l0", disp(0), 0);
    check("async_disp_l1", disp(1), 0);
    mode = 3'd0; control_data = 8'hFF;
    tick();
    reset = 1'b0;

    // ---------------- guard bands ----------------
    mode = 3'd2;
    tick();
    mode = 3'd4;
    tick();
    check("vgb_l0", 32'(sym(0)), 32'(10'b1011001100));
    check("vgb_l1", 32'(sym(1)), 32'(10'b0100110011));
    check("vgb_l2", 32'(sym(2)), 32'(10'b1011001100));
    check("vgb_l3", 32'(sym(3)), 32'(10'b1011001100));
    tick();
    check("igb_l0", 32'(sym(0)), 32'(10'b1011000011));
    check("igb_l1", 32'(sym(1)), 32'(10'b0100110011));
    check("igb_l2", 32'(sym(2)), 32'(10'b0100110011));
    check("igb_l3", 32'(sym(3)), 32'(10'b1011000011));

    // ---------------- TERC4 sweep (lane i carries v+i) ----------------
    mode = 3'd3;
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < NCH; i++)
        data_island_data[4*i +: 4] = 4'((v + i) % 16);
      tick();
      tick();
      for (int i = 0; i < NCH; i++)
        check($sformatf("terc4_v%0d_l%0d", v, i), 32'(sym(i)), 32'(terc4_tab[(v + i) % 16]));
    end
    check("terc4_disp_l0", disp(0), 0);

    // ---------------- raw / invalid modes ----------------
    mode = 3'd1; video_data = '0;
    raw_data = '0; raw_data[19:10] = 10'h2AA;
    tick();
    tick();
    check("pre_raw_sym_l1", 32'(sym(1)), 32'(10'b0100000000));
    check("pre_raw_disp_l1", disp(1), -8);
    mode = 3'd5;
    tick();
    check("pre_raw2_sym_l1", 32'(sym(1)), 32'(10'b1111111111));
    mode = 3'd7;
    tick();
    check("raw_sym_l1", 32'(sym(1)), 32'(RAW_EXP));
    check("raw_disp_l0", disp(0), 0);
    tick();
    check("invalid_hold_l1", 32'(sym(1)), 32'(RAW_EXP));
    check("invalid_disp_l1", disp(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
